// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if -- request/response bundle between the MM stage and sram_ctrl.
//   mem_access_addr      byte address (word aligned, bits [1:0] ignored)
//   mem_access_read      read request level, held while mem_stall is high
//   mem_access_write     write request level, held while mem_stall is high
//   mem_access_data_out  write data, already lane-replicated
//   mem_byte_en          write byte lanes, bit i -> data[8i+7:8i]
//   mem_access_data_in   read data back to MM, valid in DONE and held afterwards
//   mem_stall            pipeline stall while an access is in flight
//   bus_err              one-cycle out-of-range pulse
// Modports: master = MM stage side, slave = controller side.
interface sram_ctrl_if;
  logic [31:0] mem_access_addr;
  logic        mem_access_read;
  logic        mem_access_write;
  logic [31:0] mem_access_data_out;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_access_data_in;
  logic        mem_stall;
  logic        bus_err;

  modport master (
    output mem_access_addr, mem_access_read, mem_access_write,
           mem_access_data_out, mem_byte_en,
    input  mem_access_data_in, mem_stall, bus_err
  );

  modport slave (
    input  mem_access_addr, mem_access_read, mem_access_write,
           mem_access_data_out, mem_byte_en,
    output mem_access_data_in, mem_stall, bus_err
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl -- runs multi-cycle read/write cycles on a 32-bit asynchronous SRAM on
// behalf of the MM stage, stalling the pipeline until each access completes.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   mm         sram_ctrl_if.slave request/response bundle from the MM stage
//   sram_addr  SRAM word address (byte address bits [ADDR_WIDTH+1:2])
//   sram_data  bidirectional SRAM data bus, driven only while a write is in progress
//   sram_ce_n, sram_oe_n, sram_we_n  active-low SRAM strobes (registered)
//   sram_be_n  active-low SRAM byte enables (registered)
// Parameters: ADDR_WIDTH (SRAM word-address width), WAIT_CYCLES (read access time and
// write-enable pulse width in clk cycles, >= 1).
// Build option: define SRAM_CTRL_BUS_ERR_EN to reject addresses with non-zero bits above
// the SRAM range (bus_err pulse, reads return 32'hDEADBEEF). Without it those bits alias.
module sram_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            mm,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [31:0]           sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rdata_reg;
  logic [3:0]       be_reg;
  logic             drive_reg;
  logic             req;
  logic             addr_err;
  logic             cnt_last;
  logic             next_wr;
  logic [3:0]       be_src;

  assign req      = mm.mem_access_read | mm.mem_access_write;
  assign cnt_last = (cnt_reg == CNT_W'(WAIT_CYCLES - 1));

`ifdef SRAM_CTRL_BUS_ERR_EN
  logic err_reg;
  logic unused_addr;
  assign addr_err    = |mm.mem_access_addr[31:ADDR_WIDTH+2];
  assign unused_addr = ^mm.mem_access_addr[1:0];
  assign mm.bus_err  = err_reg;
`else
  logic unused_addr;
  assign addr_err    = 1'b0;
  assign unused_addr = ^{mm.mem_access_addr[31:ADDR_WIDTH+2], mm.mem_access_addr[1:0]};
  assign mm.bus_err  = 1'b0;
`endif

  // Next-state logic. Write wins when both requests are present; a write with no
  // byte lanes or an out-of-range access completes without touching the SRAM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mm.mem_access_write)
          state_next = (addr_err || (mm.mem_byte_en == 4'b0000)) ? DONE : WR_SETUP;
        else if (mm.mem_access_read)
          state_next = addr_err ? DONE : RD;
      end
      RD:       if (cnt_last) state_next = DONE;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (cnt_last) state_next = WR_HOLD;
      WR_HOLD:  state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign mm.mem_stall = ((state_reg == IDLE) && req) ||
                        ((state_reg != IDLE) && (state_reg != DONE));
  assign mm.mem_access_data_in = rdata_reg;

  // Strobes are registered from the next state so the SRAM pins never glitch.
  // On the IDLE->write edge the byte enables are not latched yet, so use the inputs.
  assign next_wr = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                   (state_next == WR_HOLD);
  assign be_src  = (state_reg == IDLE) ? mm.mem_byte_en : be_reg;

  assign sram_data = drive_reg ? wdata_reg : 32'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sram_addr <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      be_reg    <= '0;
      drive_reg <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 4'hf;
`ifdef SRAM_CTRL_BUS_ERR_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      // Counter restarts on every state change, so RD and WR_PULSE each see 0..W-1.
      cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + 1'b1;

      if ((state_reg == IDLE) && req) begin
        sram_addr <= mm.mem_access_addr[ADDR_WIDTH+1:2];
        wdata_reg <= mm.mem_access_data_out;
        be_reg    <= mm.mem_byte_en;
      end

      if ((state_reg == RD) && cnt_last)
        rdata_reg <= sram_data;
      else if ((state_reg == IDLE) && mm.mem_access_read && !mm.mem_access_write && addr_err)
        rdata_reg <= 32'hDEADBEEF;

`ifdef SRAM_CTRL_BUS_ERR_EN
      // Rejected accesses spend exactly one cycle in DONE, which is where this lands.
      err_reg <= (state_reg == IDLE) && req && addr_err;
`endif

      drive_reg <= next_wr;
      sram_ce_n <= !((state_next == RD) || next_wr);
      sram_oe_n <= !(state_next == RD);
      sram_we_n <= !(state_next == WR_PULSE);
      sram_be_n <= (state_next == RD) ? 4'h0 : (next_wr ? ~be_src : 4'hf);
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- directed bench for sram_ctrl with a behavioural SRAM device and a
// transaction-level expectation model checked on every negative clock edge.
module tb_sram_ctrl;
  localparam int W = 2;
`ifdef SRAM_CTRL_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int K_RD = 0, K_WR = 1, K_NONE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus();
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  sram_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .mm(bus),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  // External SRAM device (only the low 256 words are modelled).
  logic [31:0] sram_mem [256];
  logic [31:0] exp_mem  [256];
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'bz;
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] = sram_data[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: the access is captured when it appears, then each cycle's
  // outputs follow from its kind and the cycle index within it.
  int          phase = -1;
  int          kind, len;
  logic [31:0] t_addr, t_data, exp_din;
  logic [3:0]  t_be;
  logic        t_rd, t_err, acc;
  int          stall_cnt, oe_cnt, we_cnt, ce_cnt, err_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase   = -1;
      exp_din = 32'h0;
    end else begin
      if (phase < 0 && (bus.mem_access_read || bus.mem_access_write)) begin
        phase  = 0;
        t_addr = bus.mem_access_addr;
        t_data = bus.mem_access_data_out;
        t_be   = bus.mem_byte_en;
        t_rd   = !bus.mem_access_write;
        t_err  = ERR_EN && (t_addr[31:22] != 10'd0);
        if (!t_rd) kind = (t_be == 4'h0 || t_err) ? K_NONE : K_WR;
        else       kind = t_err ? K_NONE : K_RD;
        len = (kind == K_RD) ? W + 1 : ((kind == K_WR) ? W + 3 : 1);
        stall_cnt = 0; oe_cnt = 0; we_cnt = 0; ce_cnt = 0; err_cnt = 0;
      end
      if (phase >= 0) begin
        acc = (phase >= 1) && (phase < len);
        if (phase == len) begin
          if (t_rd) exp_din = (kind == K_RD) ? exp_mem[t_addr[9:2]] : 32'hDEADBEEF;
          if (kind == K_WR)
            for (int b = 0; b < 4; b++)
              if (t_be[b]) exp_mem[t_addr[9:2]][8*b +: 8] = t_data[8*b +: 8];
        end
        chk("stall", {31'b0, bus.mem_stall}, {31'b0, phase < len});
        chk("ce_n", {31'b0, sram_ce_n}, {31'b0, !acc});
        chk("oe_n", {31'b0, sram_oe_n}, {31'b0, !(kind == K_RD && acc)});
        chk("we_n", {31'b0, sram_we_n}, {31'b0, !(kind == K_WR && phase >= 2 && phase <= W + 1)});
        chk("be_n", {28'b0, sram_be_n}, {28'b0, acc ? ((kind == K_RD) ? 4'h0 : ~t_be) : 4'hf});
        chk("bus_err", {31'b0, bus.bus_err}, {31'b0, (phase == len) && t_err});
        chk("data_in", bus.mem_access_data_in, exp_din);
        if (acc) chk("sram_addr", {12'b0, sram_addr}, {12'b0, t_addr[21:2]});
        if (acc && kind == K_WR) chk("sram_data", sram_data, t_data);
        if (bus.mem_stall) stall_cnt++;
        if (!sram_oe_n)    oe_cnt++;
        if (!sram_we_n)    we_cnt++;
        if (!sram_ce_n)    ce_cnt++;
        if (bus.bus_err)   err_cnt++;
        phase = (phase == len) ? -1 : phase + 1;
      end else begin
        chk("idle_stall", {31'b0, bus.mem_stall}, 32'h0);
        chk("idle_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("idle_bus_err", {31'b0, bus.bus_err}, 32'h0);
        chk("idle_data_in", bus.mem_access_data_in, exp_din);
      end
    end
  end

  // Drive one request, hold it for the hand-computed stall length, drop it in DONE.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be, input int cycles);
    @(posedge clk); #1;
    bus.mem_access_read     = rd;
    bus.mem_access_write    = wr;
    bus.mem_access_addr     = addr;
    bus.mem_access_data_out = data;
    bus.mem_byte_en         = be;
    repeat (cycles) @(posedge clk);
    #1;
    bus.mem_access_read  = 1'b0;
    bus.mem_access_write = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 32'h0;
      exp_mem[i]  = 32'h0;
    end
    sram_mem[0] = 32'hA5A50001; exp_mem[0] = 32'hA5A50001;
    sram_mem[4] = 32'h12345678; exp_mem[4] = 32'h12345678;
    sram_mem[8] = 32'h55667788; exp_mem[8] = 32'h55667788;
    bus.mem_access_read = 1'b0; bus.mem_access_write = 1'b0;
    bus.mem_access_addr = 32'h0; bus.mem_access_data_out = 32'h0; bus.mem_byte_en = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    chk("rst_be_n", {28'b0, sram_be_n}, 32'hf);
    chk("rst_addr", {12'b0, sram_addr}, 32'h0);
    chk("rst_data_in", bus.mem_access_data_in, 32'h0);
    chk("rst_stall", {31'b0, bus.mem_stall}, 32'h0);
    rst_n = 1'b1;

    // 1: plain read
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3);
    chk("t1_stall_cycles", stall_cnt, 3);
    chk("t1_oe_cycles", oe_cnt, 2);
    chk("t1_data", bus.mem_access_data_in, 32'h12345678);

    // 2: partial write, then read back the merged word
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFEBABE, 4'b0011, 5);
    chk("t2_stall_cycles", stall_cnt, 5);
    chk("t2_we_cycles", we_cnt, 2);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3);
    chk("t2_readback", bus.mem_access_data_in, 32'h5566BABE);

    // 3: read and write together -> write only
    txn(1'b1, 1'b1, 32'h0000_0030, 32'h11223344, 4'hf, 5);
    chk("t3_oe_cycles", oe_cnt, 0);
    chk("t3_we_cycles", we_cnt, 2);
    chk("t3_data_held", bus.mem_access_data_in, 32'h5566BABE);
    txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 3);
    chk("t3_readback", bus.mem_access_data_in, 32'h11223344);

    // 4: write with no byte lanes
    txn(1'b0, 1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'h0, 1);
    chk("t4_stall_cycles", stall_cnt, 1);
    chk("t4_ce_cycles", ce_cnt, 0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3);
    chk("t4_readback", bus.mem_access_data_in, 32'h0);

    // 5: reset during the write pulse
    @(posedge clk); #1;
    bus.mem_access_write = 1'b1; bus.mem_access_addr = 32'h0000_0050;
    bus.mem_access_data_out = 32'h99999999; bus.mem_byte_en = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_in_pulse_we_n", {31'b0, sram_we_n}, 32'h0);
    rst_n = 1'b0;
    bus.mem_access_write = 1'b0;
    @(posedge clk); #1;
    chk("t5_we_n", {31'b0, sram_we_n}, 32'h1);
    chk("t5_ce_n", {31'b0, sram_ce_n}, 32'h1);
    chk("t5_stall", {31'b0, bus.mem_stall}, 32'h0);
    rst_n = 1'b1;
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3);
    chk("t5_read_after_rst", bus.mem_access_data_in, 32'h12345678);

    // 6: out-of-range address
    txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, ERR_EN ? 1 : 3);
    if (ERR_EN) begin
      chk("t6_err_pulses", err_cnt, 1);
      chk("t6_ce_cycles", ce_cnt, 0);
      chk("t6_data", bus.mem_access_data_in, 32'hDEADBEEF);
    end else begin
      chk("t6_err_pulses", err_cnt, 0);
      chk("t6_alias_data", bus.mem_access_data_in, 32'hA5A50001);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
